// File: rtl/frame_streamer.sv
// Streams one raster frame from a 2-cycle-latency frame memory as valid-strobed RGB565 pixels with (h,v) counts.
// Latency: first pixel 2 enabled cycles after its address; frame_done one cycle after the last pixel.
// Backpressure: hold_in freezes FSM, counters and pipeline; define FRAME_STREAMER_BORDER_EN to blank the frame border.
module frame_streamer #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int ADDR_W   = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic              hold_in,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic              mem_en_out,
  input  logic [15:0]       mem_data_in,
  output logic              data_valid_out,
  output logic [15:0]       pixel_data_out,
  output logic [10:0]       hcount_out,
  output logic [9:0]        vcount_out,
  output logic              busy_out,
  output logic              frame_done_out
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [10:0]       H_LAST   = 11'(H_ACTIVE - 1);
  localparam logic [9:0]        V_LAST   = 10'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [10:0]       h_q;
  logic [9:0]        v_q;
  logic              drain_q;
  logic              done_q;

  logic              s1_vld_q;
  logic [10:0]       s1_h_q;
  logic [9:0]        s1_v_q;
  logic              s2_vld_q;
  logic [10:0]       s2_h_q;
  logic [9:0]        s2_v_q;

  logic [15:0]       pix_last_q;
  logic [10:0]       h_last_q;
  logic [9:0]        v_last_q;

  logic              en;
  logic              last_pix;
  logic [15:0]       pix_new;

  assign en             = ~hold_in;
  assign last_pix       = (h_q == H_LAST) && (v_q == V_LAST);
  assign mem_en_out     = en;
  assign mem_addr_out   = addr_q;
  assign busy_out       = (state_q != IDLE);
  assign frame_done_out = done_q;
  assign data_valid_out = s2_vld_q & en;

  always_comb begin
    pix_new = mem_data_in;
`ifdef FRAME_STREAMER_BORDER_EN
    if (s2_h_q == 11'd0 || s2_h_q == H_LAST || s2_v_q == 10'd0 || s2_v_q == V_LAST)
      pix_new = 16'h0000;
`endif
  end

  // A stalled stage-2 pixel is not shown; the previously presented values stay on the outputs.
  assign pixel_data_out = data_valid_out ? pix_new : pix_last_q;
  assign hcount_out     = data_valid_out ? s2_h_q  : h_last_q;
  assign vcount_out     = data_valid_out ? s2_v_q  : v_last_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      h_q        <= '0;
      v_q        <= '0;
      drain_q    <= 1'b0;
      done_q     <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_h_q     <= '0;
      s1_v_q     <= '0;
      s2_vld_q   <= 1'b0;
      s2_h_q     <= '0;
      s2_v_q     <= '0;
      pix_last_q <= '0;
      h_last_q   <= '0;
      v_last_q   <= '0;
    end else begin
      pix_last_q <= pixel_data_out;
      h_last_q   <= hcount_out;
      v_last_q   <= vcount_out;
      done_q     <= 1'b0;
      if (en) begin
        s1_vld_q <= (state_q == RUN);
        s1_h_q   <= h_q;
        s1_v_q   <= v_q;
        s2_vld_q <= s1_vld_q;
        s2_h_q   <= s1_h_q;
        s2_v_q   <= s1_v_q;
        case (state_q)
          IDLE: begin
            // A start landing on the done pulse belongs to the frame just finished.
            if (start_in && !done_q) state_q <= RUN;
          end
          RUN: begin
            if (last_pix) begin
              addr_q  <= '0;
              h_q     <= '0;
              v_q     <= '0;
              drain_q <= 1'b0;
              state_q <= DRAIN;
            end else begin
              addr_q <= addr_q + ADDR_ONE;
              if (h_q == H_LAST) begin
                h_q <= '0;
                v_q <= v_q + 10'd1;
              end else begin
                h_q <= h_q + 11'd1;
              end
            end
          end
          DRAIN: begin
            if (drain_q) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              drain_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_streamer.sv
// Directed bench for frame_streamer at 4x3; the memory model returns its own address as data.
module tb_frame_streamer;
  localparam int H = 4;
  localparam int V = 3;

  logic        clk_in   = 1'b0;
  logic        rst_in   = 1'b0;
  logic        start_in = 1'b0;
  logic        hold_in  = 1'b0;
  logic [16:0] mem_addr_out;
  logic        mem_en_out;
  logic [15:0] mem_data_in;
  logic        data_valid_out;
  logic [15:0] pixel_data_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        busy_out;
  logic        frame_done_out;

  logic [15:0] m1 = 16'h0;
  logic [15:0] m2 = 16'h0;

  int total = 0;
  int bad   = 0;

  frame_streamer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(17)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .hold_in(hold_in),
    .mem_addr_out(mem_addr_out), .mem_en_out(mem_en_out), .mem_data_in(mem_data_in),
    .data_valid_out(data_valid_out), .pixel_data_out(pixel_data_out),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .busy_out(busy_out), .frame_done_out(frame_done_out)
  );

  always #5 clk_in = ~clk_in;

  // Two enabled register stages: data for the address shown in cycle c appears in cycle c+2.
  always @(posedge clk_in) begin
    if (mem_en_out) begin
      m1 <= mem_addr_out[15:0];
      m2 <= m1;
    end
  end
  assign mem_data_in = m2;

  function automatic logic [15:0] exp_pix(input int n);
`ifdef FRAME_STREAMER_BORDER_EN
    int h = n % H;
    int v = n / H;
    if (h == 0 || h == H - 1 || v == 0 || v == V - 1) return 16'h0000;
`endif
    return 16'(n);
  endfunction

  task automatic test_reset();
    rst_in = 1'b0;
    #12;
    total++; if (mem_addr_out !== 17'd0) begin bad++; $display("FAIL reset_addr got=%0h exp=0", mem_addr_out); end
    total++; if (data_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", data_valid_out); end
    total++; if (pixel_data_out !== 16'd0) begin bad++; $display("FAIL reset_pixel got=%0h exp=0", pixel_data_out); end
    total++; if (hcount_out !== 11'd0 || vcount_out !== 10'd0) begin bad++; $display("FAIL reset_hv got=%0d,%0d exp=0,0", hcount_out, vcount_out); end
    total++; if (busy_out !== 1'b0 || frame_done_out !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%b%b exp=00", busy_out, frame_done_out); end
    total++; if (mem_en_out !== 1'b1) begin bad++; $display("FAIL reset_en got=%b exp=1", mem_en_out); end
    @(negedge clk_in) rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
  endtask

  task automatic test_basic();
    int nv = 0;
    int dn = 0;
    @(posedge clk_in); #1 start_in = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk_in); #1 start_in = 1'b0; #1;
      if (c < 12) begin
        total++; if (mem_addr_out !== 17'(c) || busy_out !== 1'b1) begin bad++; $display("FAIL basic_addr c=%0d got=%0d busy=%b exp=%0d busy=1", c, mem_addr_out, busy_out, c); end
      end
      if (data_valid_out === 1'b1) begin
        total++; if (c !== nv + 2) begin bad++; $display("FAIL basic_timing pix=%0d got_cycle=%0d exp_cycle=%0d", nv, c, nv + 2); end
        total++; if (pixel_data_out !== exp_pix(nv)) begin bad++; $display("FAIL basic_pixel n=%0d got=%0h exp=%0h", nv, pixel_data_out, exp_pix(nv)); end
        total++; if (hcount_out !== 11'(nv % H) || vcount_out !== 10'(nv / H)) begin bad++; $display("FAIL basic_hv n=%0d got=%0d,%0d exp=%0d,%0d", nv, hcount_out, vcount_out, nv % H, nv / H); end
        nv++;
      end
      if (frame_done_out === 1'b1) begin
        dn++;
        total++; if (c !== 14 || busy_out !== 1'b0) begin bad++; $display("FAIL basic_done got_cycle=%0d busy=%b exp_cycle=14 busy=0", c, busy_out); end
      end
    end
    total++; if (nv !== 12) begin bad++; $display("FAIL basic_count got=%0d exp=12", nv); end
    total++; if (dn !== 1) begin bad++; $display("FAIL basic_done_count got=%0d exp=1", dn); end
  endtask

  task automatic test_hold();
    int nv = 0;
    int dn = 0;
    @(posedge clk_in); #1 start_in = 1'b1;
    for (int c = 0; c < 26; c++) begin
      @(posedge clk_in); #1 start_in = 1'b0; hold_in = (c >= 8 && c <= 10); #1;
      total++; if (mem_en_out !== ~hold_in) begin bad++; $display("FAIL hold_en c=%0d got=%b exp=%b", c, mem_en_out, ~hold_in); end
      if (hold_in === 1'b1) begin
        total++; if (data_valid_out !== 1'b0 || pixel_data_out !== exp_pix(5) || mem_addr_out !== 17'd8) begin bad++; $display("FAIL hold_freeze c=%0d got v=%b p=%0h a=%0d exp v=0 p=%0h a=8", c, data_valid_out, pixel_data_out, mem_addr_out, exp_pix(5)); end
      end
      if (data_valid_out === 1'b1) begin
        total++; if (c !== (nv < 6 ? nv + 2 : nv + 5)) begin bad++; $display("FAIL hold_timing pix=%0d got_cycle=%0d", nv, c); end
        total++; if (pixel_data_out !== exp_pix(nv)) begin bad++; $display("FAIL hold_pixel n=%0d got=%0h exp=%0h", nv, pixel_data_out, exp_pix(nv)); end
        nv++;
      end
      if (frame_done_out === 1'b1) begin
        dn++;
        total++; if (c !== 17) begin bad++; $display("FAIL hold_done got_cycle=%0d exp_cycle=17", c); end
      end
    end
    hold_in = 1'b0;
    total++; if (nv !== 12 || dn !== 1) begin bad++; $display("FAIL hold_count got=%0d/%0d exp=12/1", nv, dn); end
  endtask

  task automatic test_restart();
    int nv = 0;
    int dn = 0;
    @(posedge clk_in); #1 start_in = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk_in); #1 start_in = (c == 5 || c == 14); #1;
      if (data_valid_out === 1'b1) nv++;
      if (frame_done_out === 1'b1) dn++;
      if (c == 15) begin
        total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL restart_ignored got_busy=%b exp=0", busy_out); end
      end
    end
    start_in = 1'b0;
    total++; if (nv !== 12) begin bad++; $display("FAIL restart_valids got=%0d exp=12", nv); end
    total++; if (dn !== 1) begin bad++; $display("FAIL restart_done got=%0d exp=1", dn); end
  endtask

  task automatic test_midframe_reset();
    int nv = 0;
    int stray = 0;
    @(posedge clk_in); #1 start_in = 1'b1;
    for (int c = 0; c < 20 && nv < 8; c++) begin
      @(posedge clk_in); #1 start_in = 1'b0; #1;
      if (data_valid_out === 1'b1) nv++;
    end
    total++; if (nv !== 8) begin bad++; $display("FAIL rst_reach_pix7 got=%0d exp=8", nv); end
    #1 rst_in = 1'b0; #1;
    total++; if (mem_addr_out !== 17'd0 || data_valid_out !== 1'b0 || pixel_data_out !== 16'd0) begin bad++; $display("FAIL rst_async_data got a=%0d v=%b p=%0h exp 0", mem_addr_out, data_valid_out, pixel_data_out); end
    total++; if (hcount_out !== 11'd0 || vcount_out !== 10'd0 || busy_out !== 1'b0 || frame_done_out !== 1'b0) begin bad++; $display("FAIL rst_async_ctl got h=%0d v=%0d b=%b d=%b exp 0", hcount_out, vcount_out, busy_out, frame_done_out); end
    #1 rst_in = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk_in); #2;
      if (data_valid_out !== 1'b0 || frame_done_out !== 1'b0 || busy_out !== 1'b0) stray++;
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL rst_stray got=%0d exp=0", stray); end
    nv = 0;
    @(posedge clk_in); #1 start_in = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk_in); #1 start_in = 1'b0; #1;
      if (data_valid_out === 1'b1) begin
        total++; if (pixel_data_out !== exp_pix(nv) || c !== nv + 2) begin bad++; $display("FAIL rst_new_frame n=%0d got=%0h c=%0d exp=%0h", nv, pixel_data_out, c, exp_pix(nv)); end
        nv++;
      end
    end
    total++; if (nv !== 12) begin bad++; $display("FAIL rst_new_count got=%0d exp=12", nv); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_restart();
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
